// File: rtl/tlx_rsp_classifier_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : tlx_rsp_classifier_pkg                                         |
// | Brief     : TLX response opcodes/codes, rsp_typ indices, dl encodings.     |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package tlx_rsp_classifier_pkg;

    localparam logic [7:0] c_op_read_rsp   = 8'h04;
    localparam logic [7:0] c_op_read_fail  = 8'h05;
    localparam logic [7:0] c_op_write_rsp  = 8'h08;
    localparam logic [7:0] c_op_write_fail = 8'h09;
    localparam logic [7:0] c_op_xlate_done = 8'h18;

    localparam logic [3:0] c_rc_retry_backoff = 4'h2;
    localparam logic [3:0] c_rc_xlate_pending = 4'h4;
    localparam logic [3:0] c_xc_retry_imm     = 4'h0;
    localparam logic [3:0] c_xc_retry_backoff = 4'h2;

    localparam int c_typ_xlate_pend = 0;
    localparam int c_typ_xd_backoff = 1;
    localparam int c_typ_xd_imm     = 2;
    localparam int c_typ_backoff    = 3;
    localparam int c_typ_partial    = 4;

    localparam logic [1:0] c_dl_64b  = 2'b01;
    localparam logic [1:0] c_dl_128b = 2'b10;
    localparam logic [1:0] c_dl_256b = 2'b11;

    typedef struct packed {
        logic [1:0] dl;
        logic [3:0] mask;
    } tag_entry_t;

    // 64B pieces covered by a (dl, dp) pair; a 128B piece at dp=3 keeps only bit 3.
    function automatic logic [3:0] piece_mask(input logic [1:0] dl, input logic [1:0] dp);
        logic [3:0] m;
        case (dl)
            c_dl_64b:  m = 4'b0001 << dp;
            c_dl_128b: m = 4'b0011 << dp;
            c_dl_256b: m = 4'b1111;
            default:   m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rsp_tag_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : rsp_tag_table                                                  |
// | Brief     : Per-tag {dl, outstanding mask} flops, one read, two writes.    |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module rsp_tag_table
    import tlx_rsp_classifier_pkg::*;
#(
    parameter int TAGW = 7
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [TAGW-1:0] raddr,
    output tag_entry_t      rdata,
    input  logic            we,
    input  logic [TAGW-1:0] waddr,
    input  tag_entry_t      wdata,
    input  logic            cmd_we,
    input  logic [TAGW-1:0] cmd_addr,
    input  tag_entry_t      cmd_wdata
);

    localparam int c_depth = 2 ** TAGW;

    tag_entry_t r_mem [c_depth];

    assign rdata = r_mem[raddr];

    // The command write is issued last so it overrides a same-tag response update.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (we) begin
                r_mem[waddr] <= wdata;
            end
            if (cmd_we) begin
                r_mem[cmd_addr] <= cmd_wdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tlx_rsp_classifier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tlx_rsp_classifier                                             |
// | Brief     : Classifies TLX responses, tracks per-tag pieces, returns credit|
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tlx_rsp_classifier
    import tlx_rsp_classifier_pkg::*;
#(
    parameter int TAGW = 7
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            cmd_valid,
    input  logic [TAGW-1:0] cmd_tag,
    input  logic [1:0]      cmd_dl,
    input  logic            tlx_afu_resp_valid,
    input  logic [7:0]      tlx_afu_resp_opcode,
    input  logic [TAGW-1:0] tlx_afu_resp_afutag,
    input  logic [3:0]      tlx_afu_resp_code,
    input  logic [1:0]      tlx_afu_resp_dl,
    input  logic [1:0]      tlx_afu_resp_dp,
    output logic            afu_tlx_resp_credit,
    output logic            rsp_den,
    output logic [1:0]      rsp_pos,
    output logic [TAGW-1:0] rsp_tag,
    output logic [4:0]      rsp_typ,
    output logic            cmp_valid,
    output logic [TAGW-1:0] cmp_tag,
    output logic            err_valid,
    output logic [TAGW-1:0] err_tag,
    output logic [3:0]      err_code,
    output logic            spurious
);

    logic            r_s1_vld;
    logic [7:0]      r_s1_op;
    logic [TAGW-1:0] r_s1_tag;
    logic [3:0]      r_s1_code;
    logic [1:0]      r_s1_dl;
    logic [1:0]      r_s1_dp;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_s1_vld  <= 1'b0;
            r_s1_op   <= '0;
            r_s1_tag  <= '0;
            r_s1_code <= '0;
            r_s1_dl   <= '0;
            r_s1_dp   <= '0;
        end else begin
            r_s1_vld  <= tlx_afu_resp_valid;
            r_s1_op   <= tlx_afu_resp_opcode;
            r_s1_tag  <= tlx_afu_resp_afutag;
            r_s1_code <= tlx_afu_resp_code;
            r_s1_dl   <= tlx_afu_resp_dl;
            r_s1_dp   <= tlx_afu_resp_dp;
        end
    end

    tag_entry_t w_rd;
    tag_entry_t w_wdata;
    tag_entry_t w_cmd_wdata;
    logic       w_we;
    logic [3:0] w_new_mask;
    logic       w_idle;
    logic [4:0] w_typ;
    logic       w_den;
    logic       w_cmp;
    logic       w_err;
    logic       w_spur;

    assign w_cmd_wdata = {cmd_dl, piece_mask(cmd_dl, 2'b00)};

    rsp_tag_table #(.TAGW(TAGW)) u_tag_table (
        .clk       (clk),
        .resetn    (resetn),
        .raddr     (r_s1_tag),
        .rdata     (w_rd),
        .we        (w_we),
        .waddr     (r_s1_tag),
        .wdata     (w_wdata),
        .cmd_we    (cmd_valid),
        .cmd_addr  (cmd_tag),
        .cmd_wdata (w_cmd_wdata)
    );

    always_comb begin
        w_we       = 1'b0;
        w_wdata    = '0;
        w_typ      = '0;
        w_den      = 1'b0;
        w_cmp      = 1'b0;
        w_err      = 1'b0;
        w_spur     = 1'b0;
        w_idle     = (w_rd.mask == 4'b0000);
        w_new_mask = w_rd.mask & ~piece_mask(r_s1_dl, r_s1_dp);
        if (r_s1_vld) begin
            case (r_s1_op)
                c_op_read_rsp, c_op_write_rsp: begin
                    if (w_idle) begin
                        w_spur = 1'b1;
                    end else begin
                        w_we    = 1'b1;
                        w_wdata = {w_rd.dl, w_new_mask};
                        w_cmp   = (w_new_mask == 4'b0000);
                    end
                end
                c_op_read_fail, c_op_write_fail: begin
                    if (w_idle) begin
                        w_spur = 1'b1;
                    end else if (r_s1_code == c_rc_retry_backoff) begin
                        w_typ[c_typ_backoff] = 1'b1;
                    end else if (r_s1_code == c_rc_xlate_pending) begin
                        w_typ[c_typ_xlate_pend] = 1'b1;
                    end else begin
                        w_err = 1'b1;
                        w_we  = 1'b1;
                    end
                end
                c_op_xlate_done: begin
                    if (r_s1_code == c_xc_retry_imm) begin
                        w_typ[c_typ_xd_imm] = 1'b1;
                    end else if (r_s1_code == c_xc_retry_backoff) begin
                        w_typ[c_typ_xd_backoff] = 1'b1;
                    end else begin
                        w_err = 1'b1;
                        w_we  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        w_den                = |w_typ[3:0];
        w_typ[c_typ_partial] = w_den && (r_s1_dl < w_rd.dl);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp_den   <= 1'b0;
            rsp_pos   <= '0;
            rsp_tag   <= '0;
            rsp_typ   <= '0;
            cmp_valid <= 1'b0;
            cmp_tag   <= '0;
            err_valid <= 1'b0;
            err_tag   <= '0;
            err_code  <= '0;
            spurious  <= 1'b0;
        end else begin
            rsp_den   <= w_den;
            rsp_pos   <= w_typ[c_typ_partial] ? r_s1_dp : 2'b00;
            rsp_tag   <= w_den ? r_s1_tag : '0;
            rsp_typ   <= w_typ;
            cmp_valid <= w_cmp;
            cmp_tag   <= w_cmp ? r_s1_tag : '0;
            err_valid <= w_err;
            err_tag   <= w_err ? r_s1_tag : '0;
            err_code  <= w_err ? r_s1_code : 4'h0;
            spurious  <= spurious | w_spur;
        end
    end

    assign afu_tlx_resp_credit = r_s1_vld;

endmodule
`default_nettype wire
